efc_dac_spi: RTL and testbench



---
 rtl/efc_dac_spi_pkg.sv | 20 ++
 rtl/spi_tx_shifter.sv | 87 ++++++++
 rtl/efc_dac_spi.sv | 175 +++++++++++++++++
 tb/tb_efc_dac_spi.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/efc_dac_spi_pkg.sv
// Shared definitions for the OCXO EFC DAC SPI master: FSM encoding,
// register offsets and STATUS field positions.
package efc_dac_spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_e;

    localparam logic [7:0] OffData   = 8'h00;
    localparam logic [7:0] OffStatus = 8'h04;

    localparam int unsigned StatusBusyBit  = 0;
    localparam int unsigned StatusPendBit  = 1;
    localparam int unsigned StatusCountLsb = 16;

endpackage

// File: rtl/spi_tx_shifter.sv
// SPI mode-0 transmit engine: SCLK divider, MSB-first shift register and bit counter.
// load_i captures the word (MOSI shows the MSB at once); start_i begins clocking.
module spi_tx_shifter #(
    parameter int unsigned DATA_BITS = 16,
    parameter int unsigned CLK_DIV   = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 load_i,
    input  logic [DATA_BITS-1:0] word_i,
    input  logic                 start_i,
    output logic                 sclk_o,
    output logic                 mosi_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BitW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    logic                 active_q, active_d;
    logic                 sclk_q, sclk_d;
    logic [DivW-1:0]      div_q, div_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] sr_q, sr_d;
    logic                 div_last, bit_last;

    assign div_last = (div_q == DivW'(CLK_DIV - 1));
    assign bit_last = (bit_q == BitW'(DATA_BITS - 1));

    always_comb begin
        active_d = active_q;
        sclk_d   = sclk_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sr_d     = sr_q;
        if (load_i) begin
            sr_d = word_i;
        end
        if (start_i) begin
            active_d = 1'b1;
            sclk_d   = 1'b0;
            div_d    = '0;
            bit_d    = '0;
        end else if (active_q) begin
            if (div_last) begin
                div_d = '0;
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                end else begin
                    // Falling edge: the only place MOSI is allowed to move.
                    sclk_d = 1'b0;
                    if (bit_last) begin
                        active_d = 1'b0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sr_d  = {sr_q[DATA_BITS-2:0], 1'b0};
                    end
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            sr_q     <= '0;
        end else begin
            active_q <= active_d;
            sclk_q   <= sclk_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            sr_q     <= sr_d;
        end
    end

    assign sclk_o = sclk_q;
    assign mosi_o = sr_q[DATA_BITS-1];
    assign busy_o = active_q;
    assign done_o = active_q && sclk_q && div_last && bit_last;

endmodule

// File: rtl/efc_dac_spi.sv
// Memory-mapped SPI master for the OCXO EFC DAC: DATA/STATUS registers on iomem,
// one coalescing pending slot, and CS framing around the shift engine.
module efc_dac_spi
    import efc_dac_spi_pkg::*;
#(
    parameter int unsigned          DATA_BITS  = 16,
    parameter int unsigned          CLK_DIV    = 4,
    parameter int unsigned          CS_SETUP   = 2,
    parameter int unsigned          CS_HOLD    = 2,
    parameter int unsigned          CS_GAP     = 2,
    parameter logic [7:0]           REG_BASE   = 8'h20,
    parameter logic [DATA_BITS-1:0] RESET_CODE = 16'h8000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic        iomem_ready,
    output logic [31:0] iomem_rdata,
    output logic        dac_csb,
    output logic        dac_sclk,
    output logic        dac_mosi
);

    localparam logic [7:0] DataAddr = REG_BASE + OffData;
    localparam logic [7:0] StatAddr = REG_BASE + OffStatus;
    localparam int unsigned CntW = 16;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 csb_q, csb_d;
    logic [15:0]          count_q, count_d;
    logic                 pending_q, pending_d;
    logic [DATA_BITS-1:0] shadow_q, shadow_d;
    logic                 ready_q, ready_d;
    logic [31:0]          rdata_q, rdata_d;

    logic is_dev, hit_data, hit_stat, data_wr, consume, load, start, shift_done;
    logic unused_ok;

    assign unused_ok = ^{iomem_addr[23:8], iomem_wdata[31:16], iomem_wstrb[3:2]};

    assign is_dev   = iomem_valid && !ready_q && (iomem_addr[31:24] == 8'h03);
    assign hit_data = is_dev && (iomem_addr[7:0] == DataAddr);
    assign hit_stat = is_dev && (iomem_addr[7:0] == StatAddr);
    assign data_wr  = hit_data && (iomem_wstrb[0] || iomem_wstrb[1]);
    assign consume  = (state_q == StIdle) && pending_q;

    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        ready_d   = hit_data || hit_stat;
        rdata_d   = '0;
        // A same-cycle write wins over consume so the new word goes out next.
        if (consume) begin
            pending_d = 1'b0;
        end
        if (data_wr) begin
            for (int i = 0; i < DATA_BITS; i++) begin
                if (iomem_wstrb[i/8]) begin
                    shadow_d[i] = iomem_wdata[i];
                end
            end
            pending_d = 1'b1;
        end
        if (hit_data && (iomem_wstrb == 4'b0000)) begin
            rdata_d = 32'(shadow_q);
        end else if (hit_stat && (iomem_wstrb == 4'b0000)) begin
            rdata_d[StatusBusyBit]             = (state_q != StIdle);
            rdata_d[StatusPendBit]             = pending_q;
            rdata_d[StatusCountLsb +: 16]      = count_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        csb_d   = csb_q;
        count_d = count_q;
        load    = 1'b0;
        start   = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (pending_q) begin
                    load    = 1'b1;
                    csb_d   = 1'b0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == CntW'(CS_SETUP - 1)) begin
                    cnt_d   = '0;
                    start   = 1'b1;
                    state_d = StShift;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShift: begin
                if (shift_done) begin
                    cnt_d   = '0;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (cnt_q == CntW'(CS_HOLD - 1)) begin
                    cnt_d   = '0;
                    csb_d   = 1'b1;
                    count_d = count_q + 1'b1;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == CntW'(CS_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                csb_d   = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            csb_q     <= 1'b1;
            count_q   <= '0;
            pending_q <= 1'b1;
            shadow_q  <= RESET_CODE;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            csb_q     <= csb_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
        end
    end

    spi_tx_shifter #(
        .DATA_BITS(DATA_BITS),
        .CLK_DIV  (CLK_DIV)
    ) u_shifter (
        .clk    (clk),
        .resetn (resetn),
        .load_i (load),
        .word_i (shadow_q),
        .start_i(start),
        .sclk_o (dac_sclk),
        .mosi_o (dac_mosi),
        .busy_o (),
        .done_o (shift_done)
    );

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign dac_csb     = csb_q;

endmodule

// File: tb/tb_efc_dac_spi.sv
// Scoreboard bench for efc_dac_spi: expected DAC words and read data are queued
// by the stimulus and checked by independent pin and bus monitors.
module tb_efc_dac_spi;

    localparam int unsigned CsGap  = 2;
    localparam int unsigned XferLow = 132;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic [3:0]  iomem_wstrb = 4'b0;
    logic [31:0] iomem_addr = 32'b0;
    logic [31:0] iomem_wdata = 32'b0;
    logic        iomem_ready;
    logic [31:0] iomem_rdata;
    logic        dac_csb, dac_sclk, dac_mosi;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];
    logic [31:0] rd_q[$];

    // Pin monitor state
    logic        csb_prev = 1'b1;
    logic        sclk_prev = 1'b0;
    bit          in_xfer = 1'b0;
    bit          have_prev = 1'b0;
    int          nbits = 0;
    int          low_cnt = 0;
    int          gap_cnt = 0;
    int          xfer_cnt = 0;
    logic [15:0] cap = 16'h0;

    efc_dac_spi dut (
        .clk        (clk),
        .resetn     (resetn),
        .iomem_valid(iomem_valid),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr (iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_ready(iomem_ready),
        .iomem_rdata(iomem_rdata),
        .dac_csb    (dac_csb),
        .dac_sclk   (dac_sclk),
        .dac_mosi   (dac_mosi)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // SPI pin monitor: captures MOSI on SCLK rising edges while CSB is low.
    always @(negedge clk) begin
        if (!resetn) begin
            in_xfer   = 1'b0;
            have_prev = 1'b0;
            nbits     = 0;
            low_cnt   = 0;
            gap_cnt   = 0;
            csb_prev  = 1'b1;
            sclk_prev = 1'b0;
        end else begin
            if (!dac_csb && csb_prev) begin
                if (have_prev) check("csb_gap_min", 32'(gap_cnt >= CsGap), 32'd1);
                in_xfer = 1'b1;
                nbits   = 0;
                low_cnt = 0;
                cap     = 16'h0;
            end else if (dac_csb && !csb_prev && in_xfer) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer", 32'(cap), 32'hFFFF_FFFF);
                end else begin
                    check("mosi_word", 32'(cap), 32'(exp_q.pop_front()));
                end
                check("sclk_rises", 32'(nbits), 32'd16);
                check("csb_low_cycles", 32'(low_cnt), 32'(XferLow));
                in_xfer   = 1'b0;
                have_prev = 1'b1;
                gap_cnt   = 1;
                xfer_cnt++;
            end else if (dac_csb) begin
                gap_cnt++;
            end
            if (!dac_csb) begin
                low_cnt++;
                if (dac_sclk && !sclk_prev) begin
                    cap = {cap[14:0], dac_mosi};
                    nbits++;
                end
            end
            csb_prev  = dac_csb;
            sclk_prev = dac_sclk;
        end
    end

    // Bus monitor: compares read data whenever a read is acknowledged.
    always @(negedge clk) begin
        if (resetn && iomem_ready && iomem_wstrb == 4'b0000) begin
            if (rd_q.size() == 0) check("unexpected_read", iomem_rdata, 32'hDEAD_DEAD);
            else check("rdata", iomem_rdata, rd_q.pop_front());
        end
    end

    task automatic bus(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                       input bit ack, input logic [31:0] exp_rd);
        bit seen;
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = wd;
        if (ack && strb == 4'b0000) rd_q.push_back(exp_rd);
        if (ack) begin
            @(negedge clk);
            check("ack_latency", 32'(iomem_ready), 32'd1);
            iomem_valid = 1'b0;
            @(negedge clk);
            check("ack_width", 32'(iomem_ready), 32'd0);
        end else begin
            seen = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (iomem_ready) seen = 1'b1;
            end
            check("no_ack_foreign", 32'(seen), 32'd0);
            iomem_valid = 1'b0;
        end
        iomem_wstrb = 4'b0000;
    endtask

    task automatic wait_xfers(input int target);
        bit ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (xfer_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check("xfer_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        // Reset values and automatic midscale transfer
        exp_q.push_back(16'h8000);
        repeat (3) @(negedge clk);
        check("rst_csb", 32'(dac_csb), 32'd1);
        check("rst_sclk", 32'(dac_sclk), 32'd0);
        check("rst_mosi", 32'(dac_mosi), 32'd0);
        check("rst_ready", 32'(iomem_ready), 32'd0);
        check("rst_rdata", iomem_rdata, 32'd0);
        resetn = 1'b1;
        wait_xfers(1);
        repeat (5) @(negedge clk);
        bus(32'h0300_0024, 4'b0000, 32'h0, 1'b1, 32'h0001_0000);

        // Byte-strobed write, readback, then coalesced writes mid-transfer
        exp_q.push_back(16'h1234);
        bus(32'h0300_0020, 4'b0011, 32'h0000_1234, 1'b1, 32'h0);
        bus(32'h0300_0020, 4'b0000, 32'h0, 1'b1, 32'h0000_1234);
        repeat (10) @(negedge clk);
        bus(32'h0300_0020, 4'b0011, 32'h0000_AAAA, 1'b1, 32'h0);
        bus(32'h0300_0020, 4'b0011, 32'h0000_5555, 1'b1, 32'h0);
        exp_q.push_back(16'h5555);
        bus(32'h0300_0024, 4'b0000, 32'h0, 1'b1, 32'h0001_0003);
        wait_xfers(3);
        repeat (5) @(negedge clk);
        bus(32'h0300_0024, 4'b0000, 32'h0, 1'b1, 32'h0003_0000);

        // Single-byte merge and an ignored upper-byte write
        exp_q.push_back(16'h1234);
        bus(32'h0300_0020, 4'b1111, 32'h0000_1234, 1'b1, 32'h0);
        wait_xfers(4);
        exp_q.push_back(16'h12FF);
        bus(32'h0300_0020, 4'b0001, 32'h0000_00FF, 1'b1, 32'h0);
        wait_xfers(5);
        bus(32'h0300_0020, 4'b1100, 32'hFFFF_FFFF, 1'b1, 32'h0);
        repeat (5) @(negedge clk);
        bus(32'h0300_0020, 4'b0000, 32'h0, 1'b1, 32'h0000_12FF);
        bus(32'h0300_0024, 4'b0000, 32'h0, 1'b1, 32'h0005_0000);

        // Asynchronous reset in the middle of a transfer
        bus(32'h0300_0020, 4'b0011, 32'h0000_BEEF, 1'b1, 32'h0);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_xfer && nbits == 7) begin
                ok = 1'b1;
                break;
            end
        end
        check("reach_bit7", 32'(ok), 32'd1);
        #1 resetn = 1'b0;
        #1;
        check("async_rst_csb", 32'(dac_csb), 32'd1);
        check("async_rst_sclk", 32'(dac_sclk), 32'd0);
        exp_q.delete();
        exp_q.push_back(16'h8000);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        wait_xfers(6);
        repeat (5) @(negedge clk);
        bus(32'h0300_0024, 4'b0000, 32'h0, 1'b1, 32'h0001_0000);

        // Foreign addresses must not be acknowledged
        bus(32'h0300_0004, 4'b0000, 32'h0, 1'b0, 32'h0);
        bus(32'h0400_0020, 4'b0011, 32'h0000_7777, 1'b0, 32'h0);
        repeat (300) @(negedge clk);

        check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        check("rd_queue_empty", 32'(rd_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
